// File: rtl/mig_app_pkg.sv
// mig_app_pkg: shared constants and command-queue entry type for the MIG app-interface responder.
package mig_app_pkg;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;
    localparam int APP_ADDR_W = 29;
    localparam int APP_DATA_W = 256;
    localparam int APP_MASK_W = 32;

    typedef struct packed {
        logic [2:0]            cmd;
        logic [APP_ADDR_W-1:0] addr;
    } app_cmd_t;

    typedef enum logic {ST_CALIB, ST_RUN} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, show-ahead head and full/empty flags.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    always_comb begin
        full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        empty   = wp == rp;
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rp[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(do_push);
            rp <= rp + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mig_app_responder.sv
// mig_app_responder: MIG 7-series app_* responder backed by an internal RAM, in-order fixed-latency reads.
// Define MIG_RESP_STALL_EN to add LFSR-driven pseudo-random app_rdy/app_wdf_rdy backpressure.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int ADDR_LSB     = 3,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 100
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic [APP_ADDR_W-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [APP_DATA_W-1:0] app_wdf_data,
    input  logic [APP_MASK_W-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [APP_DATA_W-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  cmd_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam int WDF_W = APP_MASK_W + APP_DATA_W;

    state_t                state, state_nxt;
    logic [CW-1:0]         calib_cnt;
    logic                  run;
    logic                  stall_cmd, stall_wdf;
    app_cmd_t              cmd_din, cmd_head;
    logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [WDF_W-1:0]      wdf_head;
    logic                  wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic [APP_MASK_W-1:0] wdf_mask;
    logic [APP_DATA_W-1:0] wdf_data;
    logic                  is_wr, is_rd, rd_go, bad_go;
    logic [IDX_W-1:0]      idx;
    logic [APP_DATA_W-1:0] ram [DEPTH];
    logic [RD_LATENCY-1:0] rd_vld;
    logic [APP_DATA_W-1:0] rd_dat [RD_LATENCY];
    logic                  unused_addr;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst)
            state <= ST_CALIB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == ST_CALIB && calib_cnt == CW'(CALIB_CYCLES - 1)) ? ST_RUN : state;
    end

    always_comb begin
        run                 = state == ST_RUN;
        init_calib_complete = run;
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst)
            calib_cnt <= '0;
        else if (state == ST_CALIB)
            calib_cnt <= calib_cnt + CW'(1);
    end

`ifdef MIG_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall_cmd = lfsr[1:0] == 2'b00;
    assign stall_wdf = lfsr[3:2] == 2'b00;
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // A write only leaves the queue together with its data beat, which keeps commands and data paired.
    always_comb begin
        app_rdy     = run && !cmd_full && !stall_cmd;
        app_wdf_rdy = run && !wdf_full && !stall_wdf;
        cmd_push    = app_en && app_rdy;
        wdf_push    = app_wdf_wren && app_wdf_rdy;
        cmd_din     = {app_cmd, app_addr};
        is_wr       = cmd_head.cmd == APP_CMD_WRITE;
        is_rd       = cmd_head.cmd == APP_CMD_READ;
        wdf_pop     = !cmd_empty && is_wr && !wdf_empty;
        cmd_pop     = !cmd_empty && (!is_wr || !wdf_empty);
        rd_go       = cmd_pop && is_rd;
        bad_go      = cmd_pop && !is_wr && !is_rd;
        idx         = cmd_head.addr[ADDR_LSB +: IDX_W];
        wdf_mask    = wdf_head[WDF_W-1 -: APP_MASK_W];
        wdf_data    = wdf_head[APP_DATA_W-1:0];
    end

    assign unused_addr = ^cmd_head.addr;

    sync_fifo #(.W($bits(app_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(.W(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (wdf_push),
        .din   ({app_wdf_mask, app_wdf_data}),
        .pop   (wdf_pop),
        .dout  (wdf_head),
        .full  (wdf_full),
        .empty (wdf_empty)
    );

    always_ff @(posedge ui_clk) begin
        if (wdf_pop && !ui_clk_sync_rst)
            for (int b = 0; b < APP_MASK_W; b++)
                if (!wdf_mask[b])
                    ram[idx][b*8 +: 8] <= wdf_data[b*8 +: 8];
    end

    // Read data is captured at pop time, so later writes cannot disturb a read already in flight.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                rd_dat[i] <= '0;
        end else begin
            rd_vld[0] <= rd_go;
            rd_dat[0] <= rd_go ? ram[idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_dat[i] <= rd_dat[i-1];
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst)
            cmd_err <= 1'b0;
        else if (bad_go || (wdf_push && !app_wdf_end))
            cmd_err <= 1'b1;
    end

    assign app_rd_data       = rd_dat[RD_LATENCY-1];
    assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld[RD_LATENCY-1];
endmodule

// File: tb/tb_mig_app_responder.sv
// tb_mig_app_responder: directed self-checking bench for mig_app_responder with default parameters.
module tb_mig_app_responder;
    import mig_app_pkg::*;

    logic         ui_clk = 1'b0;
    logic         ui_clk_sync_rst = 1'b1;
    logic [28:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [255:0] app_wdf_data = '0;
    logic [31:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         cmd_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [255:0] rx [$];
    int           rxc [$];

    localparam logic [255:0] PAT_A    = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_Q    = {8{32'h0BAD_F00D}};
    localparam logic [255:0] EXP_MASK = {{16{8'hFF}}, {16{8'h00}}};

    mig_app_responder dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .cmd_err             (cmd_err)
    );

    always #5 ui_clk = ~ui_clk;

    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge ui_clk) begin
        if (app_rd_data_valid) begin
            rx.push_back(app_rd_data);
            rxc.push_back(cyc);
            check("rd_end", app_rd_data_end, 1'b1);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ui_clk);
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
        int n = 0;
        app_en = 1'b1;
        app_cmd = c;
        app_addr = a;
        while (!app_rdy && n < 500) begin
            @(negedge ui_clk);
            n++;
        end
        if (!app_rdy) check("cmd_accept", app_rdy, 1'b1);
        last_acc = cyc;
        @(negedge ui_clk);
        app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [255:0] d, input logic [31:0] m, input logic e);
        int n = 0;
        app_wdf_wren = 1'b1;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end = e;
        while (!app_wdf_rdy && n < 500) begin
            @(negedge ui_clk);
            n++;
        end
        if (!app_wdf_rdy) check("wdf_accept", app_wdf_rdy, 1'b1);
        @(negedge ui_clk);
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
    endtask

    task automatic read_word(input logic [28:0] a, output logic [255:0] d);
        int n = 0;
        rx.delete();
        rxc.delete();
        send_cmd(APP_CMD_READ, a);
        while (rx.size() == 0 && n < 40) begin
            @(negedge ui_clk);
            n++;
        end
        d = '0;
        if (rx.size() == 0) check("rd_timeout", rx.size(), 1);
        else d = rx[0];
    endtask

    task automatic wait_calib(output int n);
        logic early = 1'b0;
        n = 0;
        while (!init_calib_complete && n < 300) begin
            @(negedge ui_clk);
            n++;
            if ((app_rdy || app_wdf_rdy) && !init_calib_complete) early = 1'b1;
        end
        check("rdy_before_calib", early, 1'b0);
    endtask

    initial begin
        logic [255:0] d;
        int n, bad, t0;
        wait_cycles(3);
        check("rst_rdy", app_rdy, 1'b0);
        check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        check("rst_valid", app_rd_data_valid, 1'b0);
        check("rst_data", app_rd_data, '0);
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        ui_clk_sync_rst = 1'b0;
        wait_calib(n);
        check("calib_cycles", n, 100);
        check("run_rdy", app_rdy, 1'b1);
        check("run_wdf_rdy", app_wdf_rdy, 1'b1);

        for (int i = 0; i < 20; i++) begin
            send_wdf(256'(2 * (i + 1)), '0, 1'b1);
            send_cmd(APP_CMD_WRITE, 29'(8 * i));
        end
        wait_cycles(5);
        rx.delete();
        rxc.delete();
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            send_cmd(APP_CMD_READ, 29'(8 * i));
            if (i == 0) t0 = last_acc;
        end
        wait_cycles(20);
        check("seq_count", rx.size(), 20);
        bad = 0;
        for (int i = 0; i < rx.size(); i++) begin
            check("seq_data", rx[i], 256'(2 * (i + 1)));
            if (rxc[i] != rxc[0] + i) bad++;
        end
        if (rx.size() > 0) check("seq_latency", rxc[0] - t0, 9);
        check("seq_b2b", bad, 0);

        send_cmd(APP_CMD_WRITE, 29'd200);
        wait_cycles(1);
        send_wdf(PAT_A, '0, 1'b1);
        send_wdf(PAT_A, '0, 1'b1);
        wait_cycles(1);
        send_cmd(APP_CMD_WRITE, 29'd208);
        wait_cycles(3);
        read_word(29'd200, d);
        check("data_after_cmd", d, PAT_A);
        read_word(29'd208, d);
        check("data_before_cmd", d, PAT_A);
        check("order_err", cmd_err, 1'b0);

        send_wdf('0, '0, 1'b1);
        send_cmd(APP_CMD_WRITE, 29'd216);
        send_wdf('1, 32'h0000_FFFF, 1'b1);
        send_cmd(APP_CMD_WRITE, 29'd216);
        read_word(29'd216, d);
        check("byte_mask", d, EXP_MASK);

        rx.delete();
        rxc.delete();
        send_cmd(APP_CMD_WRITE, 29'd256);
        send_cmd(APP_CMD_READ, 29'd256);
        send_cmd(APP_CMD_WRITE, 29'd264);
        send_cmd(APP_CMD_READ, 29'd264);
        check("full_rdy", app_rdy, 1'b0);
        app_en = 1'b1;
        app_cmd = APP_CMD_WRITE;
        app_addr = 29'd272;
        wait_cycles(3);
        check("full_rdy_held", app_rdy, 1'b0);
        check("full_wdf_rdy", app_wdf_rdy, 1'b1);
        fork
            begin
                send_cmd(APP_CMD_WRITE, 29'd272);
                send_cmd(APP_CMD_READ, 29'd272);
            end
            begin
                send_wdf({8{32'hA1A1_0001}}, '0, 1'b1);
                send_wdf({8{32'hA2A2_0002}}, '0, 1'b1);
                send_wdf({8{32'hA3A3_0003}}, '0, 1'b1);
            end
        join
        wait_cycles(20);
        check("stall_count", rx.size(), 3);
        if (rx.size() == 3) begin
            check("stall_rd0", rx[0], {8{32'hA1A1_0001}});
            check("stall_rd1", rx[1], {8{32'hA2A2_0002}});
            check("stall_rd2", rx[2], {8{32'hA3A3_0003}});
        end

        rx.delete();
        rxc.delete();
        send_cmd(3'b011, 29'd0);
        wait_cycles(15);
        check("ill_no_valid", rx.size(), 0);
        check("ill_err", cmd_err, 1'b1);
        read_word(29'd512, d);
        check("alias_idx0", d, 256'd2);
        check("ill_err_sticky", cmd_err, 1'b1);

        rx.delete();
        rxc.delete();
        send_cmd(APP_CMD_READ, 29'd8);
        wait_cycles(2);
        ui_clk_sync_rst = 1'b1;
        wait_cycles(2);
        check("mid_rst_rdy", app_rdy, 1'b0);
        check("mid_rst_calib", init_calib_complete, 1'b0);
        check("mid_rst_err", cmd_err, 1'b0);
        check("mid_rst_valid", app_rd_data_valid, 1'b0);
        ui_clk_sync_rst = 1'b0;
        wait_calib(n);
        check("recalib_cycles", n, 100);
        check("mid_rst_flush", rx.size(), 0);

        send_wdf(PAT_Q, '0, 1'b0);
        send_cmd(APP_CMD_WRITE, 29'd248);
        wait_cycles(2);
        check("end_mismatch_err", cmd_err, 1'b1);
        read_word(29'd248, d);
        check("end_mismatch_stored", d, PAT_Q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
